// File: rtl/ebpf_shift_arbiter_pkg.sv
// Shared types for the eBPF shift arbiter: shift opcodes, output-stage states,
// the request bundle passed to the shift core, and shift-amount masks.
package ebpf_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSH  = 2'b00,
    SH_RSH  = 2'b01,
    SH_ARSH = 2'b10,
    SH_ILL  = 2'b11
  } shift_op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  localparam logic [4:0] SH32_MASK = 5'h1F;
  localparam logic [5:0] SH64_MASK = 6'h3F;

  typedef struct packed {
    shift_op_t   op;
    logic        is64;
    logic [63:0] a;
    logic [63:0] b;
  } shift_req_t;

  function automatic logic [63:0] zext32(input logic [31:0] v);
    return {32'h0000_0000, v};
  endfunction

endpackage

// File: rtl/ebpf_shift_arbiter_if.sv
// Request/response bundle between the requesters and the shift arbiter.
interface ebpf_shift_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][1:0]        req_op;
  logic [NUM_REQ-1:0]             req_is64;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [DATA_W-1:0]              rsp_data;
  logic                           rsp_err;

  modport master (
    output req_valid, req_op, req_is64, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_is64, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/ebpf_shift_arbiter_core.sv
// Combinational eBPF shift unit: ALU64 uses a 6-bit amount on the full word,
// ALU32 a 5-bit amount on the low word with the result zero-extended.
module ebpf_shift_core
  import ebpf_shift_pkg::*;
(
  input  shift_req_t  req_i,
  output logic [63:0] data_o,
  output logic        err_o
);

  logic [5:0]  sh64_s;
  logic [4:0]  sh32_s;
  logic [31:0] a32_s;
  logic        unused_b_s;

  assign sh64_s     = req_i.b[5:0] & SH64_MASK;
  assign sh32_s     = req_i.b[4:0] & SH32_MASK;
  assign a32_s      = req_i.a[31:0];
  assign unused_b_s = ^req_i.b[63:6];

  // Select the shift flavour; illegal ops yield zero data with the error flag.
  always_comb begin
    data_o = 64'h0;
    err_o  = 1'b0;
    case (req_i.op)
      SH_LSH: begin
        if (req_i.is64) data_o = req_i.a << sh64_s;
        else            data_o = zext32(a32_s << sh32_s);
      end
      SH_RSH: begin
        if (req_i.is64) data_o = req_i.a >> sh64_s;
        else            data_o = zext32(a32_s >> sh32_s);
      end
      SH_ARSH: begin
        if (req_i.is64) data_o = $unsigned($signed(req_i.a) >>> sh64_s);
        else            data_o = zext32($unsigned($signed(a32_s) >>> sh32_s));
      end
      SH_ILL: begin
        data_o = 64'h0;
        err_o  = 1'b1;
      end
      default: begin
        data_o = 64'h0;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ebpf_shift_arbiter.sv
// Round-robin arbiter sharing one eBPF shift core between NUM_REQ requesters,
// with a single registered valid/ready response stage.
module ebpf_shift_arbiter
  import ebpf_shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic         clk,
  input logic         rst_n,
  ebpf_shift_if.slave bus
);

  out_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              can_accept_s;
  logic              accept_s;
  logic              grant_found_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic [ID_W-1:0]   cand_idx_s;
  int                cand_s;
  logic [NUM_REQ-1:0] req_ready_s;
  shift_req_t        sel_req_s;
  logic [63:0]       core_data_s;
  logic              core_err_s;

  // A full stage frees up in the same cycle the consumer takes it.
  assign can_accept_s = (state_q == ST_EMPTY) || bus.rsp_ready;
  assign accept_s     = can_accept_s && grant_found_s && rst_n;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    cand_s        = 0;
    cand_idx_s    = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s     = int'(rr_q) + k;
      cand_s     = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
      cand_idx_s = ID_W'(cand_s);
      if (!grant_found_s && bus.req_valid[cand_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot ready for the granted requester, only when the stage can load.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_s[k] = accept_s && (grant_idx_s == ID_W'(k));
    end
  end

  assign sel_req_s.op   = shift_op_t'(bus.req_op[grant_idx_s]);
  assign sel_req_s.is64 = bus.req_is64[grant_idx_s];
  assign sel_req_s.a    = bus.req_a[grant_idx_s];
  assign sel_req_s.b    = bus.req_b[grant_idx_s];

  ebpf_shift_core u_core (
    .req_i  (sel_req_s),
    .data_o (core_data_s),
    .err_o  (core_err_s)
  );

  // Output-stage state, pointer advance and result capture.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) state_d = ST_FULL;
        else          state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (accept_s)           state_d = ST_FULL;
        else if (bus.rsp_ready) state_d = ST_EMPTY;
        else                    state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept_s) begin
      rr_d   = (grant_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
      id_d   = grant_idx_s;
      data_d = DATA_W'(core_data_s);
      err_d  = core_err_s;
    end else begin
      rr_d   = rr_q;
      id_d   = id_q;
      data_d = data_q;
      err_d  = err_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      rr_q    <= {ID_W{1'b0}};
      id_q    <= {ID_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_ebpf_shift_arbiter.sv
// Directed self-checking bench for ebpf_shift_arbiter (NUM_REQ=2).
module tb_ebpf_shift_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ebpf_shift_if #(.NUM_REQ(2), .DATA_W(64), .ID_W(1)) bus ();

  ebpf_shift_arbiter #(.NUM_REQ(2), .DATA_W(64), .ID_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic idx, input logic [1:0] op, input logic is64,
                       input logic [63:0] a, input logic [63:0] b);
    bus.req_op[idx]    = op;
    bus.req_is64[idx]  = is64;
    bus.req_a[idx]     = a;
    bus.req_b[idx]     = b;
    bus.req_valid[idx] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #3;
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid); end
    vectors++; if (bus.rsp_data !== 64'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_id: got %b want 0", bus.rsp_id); end
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.rsp_err); end
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_arsh32();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(1'b0, 2'b10, 1'b0, 64'h0000_0000_8000_0000, 64'd4);
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL arsh32_ready: got %b want 01", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL arsh32_valid: got %b want 1", bus.rsp_valid); end
    vectors++; if (bus.rsp_data !== 64'h0000_0000_F800_0000) begin miscompares++; $display("FAIL arsh32_data: got %h want 00000000f8000000", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL arsh32_id: got %b want 0", bus.rsp_id); end
  endtask

  task automatic test_masking();
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b1, 64'h8000_0000_0000_0000, 64'd68);
    #1;
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL arsh64_ready: got %b want 10", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b00;
    drive(1'b0, 2'b00, 1'b0, 64'hFFFF_FFFF_0000_0001, 64'd33);
    #1;
    vectors++; if (bus.rsp_data !== 64'hF800_0000_0000_0000) begin miscompares++; $display("FAIL arsh64_data: got %h want f800000000000000", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== 1'b1) begin miscompares++; $display("FAIL arsh64_id: got %b want 1", bus.rsp_id); end
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL lsh32_ready: got %b want 01", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.rsp_data !== 64'h0000_0000_0000_0002) begin miscompares++; $display("FAIL lsh32_data: got %h want 0000000000000002", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL lsh32_id: got %b want 0", bus.rsp_id); end
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL lsh32_err: got %b want 0", bus.rsp_err); end
  endtask

  task automatic test_contention();
    logic [63:0] exp_data;
    logic [1:0]  exp_ready;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 2'b00, 1'b1, 64'd1, 64'd0);
    drive(1'b1, 2'b00, 1'b1, 64'd2, 64'd1);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c > 0) begin
        exp_data = ((c - 1) % 2 == 1) ? 64'd4 : 64'd1;
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rr_valid[%0d]: got %b want 1", c, bus.rsp_valid); end
        vectors++; if (bus.rsp_id !== 1'((c - 1) % 2)) begin miscompares++; $display("FAIL rr_id[%0d]: got %b want %0d", c, bus.rsp_id, (c - 1) % 2); end
        vectors++; if (bus.rsp_data !== exp_data) begin miscompares++; $display("FAIL rr_data[%0d]: got %h want %h", c, bus.rsp_data, exp_data); end
      end
      exp_ready = (c % 2 == 1) ? 2'b10 : 2'b01;
      vectors++; if (bus.req_ready !== exp_ready) begin miscompares++; $display("FAIL rr_ready[%0d]: got %b want %b", c, bus.req_ready, exp_ready); end
      @(posedge clk); @(negedge clk);
    end
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.rsp_id !== 1'b1) begin miscompares++; $display("FAIL rr_id_last: got %b want 1", bus.rsp_id); end
    vectors++; if (bus.rsp_data !== 64'd4) begin miscompares++; $display("FAIL rr_data_last: got %h want 4", bus.rsp_data); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(1'b0, 2'b00, 1'b1, 64'h10, 64'd4);
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    drive(1'b1, 2'b01, 1'b1, 64'h100, 64'd4);
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", k, bus.rsp_valid); end
      vectors++; if (bus.rsp_data !== 64'h100) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want 100", k, bus.rsp_data); end
      vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL bp_id[%0d]: got %b want 0", k, bus.rsp_id); end
      vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 00", k, bus.req_ready); end
      @(posedge clk); @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_release_ready: got %b want 10", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_b2b_valid: got %b want 1", bus.rsp_valid); end
    vectors++; if (bus.rsp_data !== 64'h10) begin miscompares++; $display("FAIL bp_b2b_data: got %h want 10", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== 1'b1) begin miscompares++; $display("FAIL bp_b2b_id: got %b want 1", bus.rsp_id); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(1'b0, 2'b11, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'd3);
    drive(1'b1, 2'b00, 1'b0, 64'hAAAA_AAAA_0000_0003, 64'd32);
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL ill_ready0: got %b want 01", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    #1;
    vectors++; if (bus.rsp_err !== 1'b1) begin miscompares++; $display("FAIL ill_err: got %b want 1", bus.rsp_err); end
    vectors++; if (bus.rsp_data !== 64'h0) begin miscompares++; $display("FAIL ill_data: got %h want 0", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL ill_id: got %b want 0", bus.rsp_id); end
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL ill_rr_advance: got %b want 10", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL sh0_err: got %b want 0", bus.rsp_err); end
    vectors++; if (bus.rsp_data !== 64'h0000_0000_0000_0003) begin miscompares++; $display("FAIL sh0_data: got %h want 3", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== 1'b1) begin miscompares++; $display("FAIL sh0_id: got %b want 1", bus.rsp_id); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b0, 2'b00, 1'b1, 64'd1, 64'd1);
    drive(1'b1, 2'b00, 1'b1, 64'd5, 64'd1);
    @(posedge clk); @(negedge clk);
    #1;
    vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL mid_full: got %b want 1", bus.rsp_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_valid: got %b want 0", bus.rsp_valid); end
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL mid_async_ready: got %b want 00", bus.req_ready); end
    vectors++; if (bus.rsp_data !== 64'h0) begin miscompares++; $display("FAIL mid_async_data: got %h want 0", bus.rsp_data); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL mid_hold_ready: got %b want 00", bus.req_ready); end
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL mid_first_grant: got %b want 01", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL mid_rsp_id: got %b want 0", bus.rsp_id); end
    vectors++; if (bus.rsp_data !== 64'd2) begin miscompares++; $display("FAIL mid_rsp_data: got %h want 2", bus.rsp_data); end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op    = '{2'b00, 2'b00};
    bus.req_is64  = 2'b00;
    bus.req_a     = '{64'h0, 64'h0};
    bus.req_b     = '{64'h0, 64'h0};
    bus.rsp_ready = 1'b0;
    test_reset();
    test_arsh32();
    test_masking();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ebpf_shift_arbiter.md
Name: ebpf_shift_arbiter

Overview:
- Shares one registered eBPF shift datapath (LSH, RSH, ARSH) between NUM_REQ requesters, for example the ALU issue slot and the helper/offload path.
- Arbitrates round-robin and applies eBPF ALU/ALU64 semantics: shift-amount masking and 32-bit zero-extension.
- Returns a tagged result through a single valid/ready response port.
- Sits between the core's decode/issue logic and the writeback mux.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 64, operand and result width; fixed at 64 for eBPF.
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the requester tag.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request present, per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_op  in  NUM_REQ x 2  shift op: 00 LSH, 01 RSH, 10 ARSH, 11 illegal
- req_is64  in  NUM_REQ  1 = ALU64, 0 = ALU32
- req_a  in  NUM_REQ x DATA_W  operand to shift (dst)
- req_b  in  NUM_REQ x DATA_W  shift amount (src/imm)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_data  out  DATA_W  shift result
- rsp_err  out  1  illegal op flag

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - Round-robin pointer rr=0.
  - req_ready=0 throughout reset.
  - An in-flight result is discarded. No request is accepted until the first clock edge after rst_n rises.
- Output stage states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp_ready with no new accept.
  - FULL→FULL on rsp_ready together with a new accept; the output register is reloaded.
- Accept condition: can_accept = !rsp_valid || rsp_ready. When can_accept is 0, all req_ready are 0 and the output holds stable.
- Grant:
  - Among the asserted req_valid, grant the first index at or after rr, modulo NUM_REQ.
  - req_ready[g]=1 only when can_accept; this is combinational from req_valid.
  - On accept, rr <= g+1 mod NUM_REQ. rr is unchanged when nothing is accepted.
- Latency and throughput:
  - Accept at edge N; rsp_valid, rsp_data, rsp_id and rsp_err are visible after edge N.
  - Sustained throughput is 1 result per cycle while rsp_ready=1.
- Arithmetic, is64=1:
  - sh = b[5:0].
  - LSH = a<<sh.
  - RSH = a>>sh, logical.
  - ARSH = signed a>>>sh.
- Arithmetic, is64=0:
  - sh = b[4:0], applied to a[31:0].
  - ARSH sign source is bit 31.
  - The 32-bit result is zero-extended to 64; the upper 32 bits are always 0.
- Illegal op (11): rsp_data=0, rsp_err=1. It still completes as a normal transaction and still advances rr.
- Shift amounts: b bits above the mask are ignored, and a masked amount of 0 returns a unchanged (truncated/zero-extended in ALU32).
- Requester obligation: a requester holds req_op, req_is64, req_a and req_b stable while req_valid && !req_ready. A withdrawn req_valid is legal and simply loses priority for that cycle.

Decomposition:
- Package ebpf_shift_pkg holds:
  - typedef enum logic[1:0] shift_op_t {SH_LSH, SH_RSH, SH_ARSH, SH_ILL}.
  - localparams SH32_MASK=5'h1F and SH64_MASK=6'h3F.
  - typedef struct shift_req_t {op, is64, a, b}.
- One combinational sub-module, ebpf_shift_core (shift_req_t in → data, err out), instantiated once after the grant mux.
- The arbiter, rr pointer and output register live in ebpf_shift_arbiter.

Test Plan:
- ARSH32: req0 a=0x0000_0000_8000_0000, b=4 → rsp_data=0x0000_0000_F800_0000, rsp_id=0, one cycle after accept.
- ARSH64 with masking: req1 a=0x8000_0000_0000_0000, b=68 → sh=4, rsp_data=0xF800_0000_0000_0000. LSH32 a=0xFFFF_FFFF_0000_0001, b=33 → 0x0000_0000_0000_0002.
- Contention: both requesters valid continuously with rsp_ready=1 → grants alternate 0,1,0,1. rsp_id sequence matches with no bubble, and rr starts at 0 after reset.
- Backpressure: rsp_ready=0 for 3 cycles with result FULL → rsp_* stable, req_ready=0. Raising rsp_ready then accepts the pending request in that same cycle, giving a back-to-back result.
- Illegal op: req0 op=11 → rsp_err=1, rsp_data=0, and rr advances so req1 is granted next.
- Reset mid-operation: assert rst_n=0 while FULL and both requesters valid → rsp_valid drops immediately (asynchronously) and req_ready=0. After release, the first grant goes to req0.
